fetch_mem_sequencer: RTL and testbench

//  Memory-access sequencer and instruction/data capture stage directly upstream of the control unit.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_mem_sequencer.sv | 105 ++++++++++
 tb/tb_fetch_mem_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared state encoding, instruction field positions and opcodes for the fetch/memory front end.
// Purely declarative: no logic, no latency, no flow control.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } seq_state_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int FUNCT_W = 6;
  localparam int REG_W   = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_LUI   = 6'h0f;

endpackage

// File: rtl/fetch_mem_sequencer.sv
// Single-outstanding memory sequencer holding IR/MDR; done pulses LAT+1 cycles after req is taken.
// No backpressure: a req arriving while busy (including the DONE cycle) is dropped and flagged in req_drop.
module fetch_mem_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic              req_iord,
  input  logic              req_to_ir,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              req_drop,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_LAT - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             to_ir_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      to_ir_q   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      req_drop  <= 1'b0;
      ir        <= '0;
      mdr       <= '0;
    end else begin
      done <= 1'b0;
      // Only IDLE accepts work; anything else, DONE included, counts as a drop.
      if (req && state != IDLE) req_drop <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            mem_addr  <= req_iord ? alu_addr : pc_addr;
            mem_wdata <= wdata;
            we_q      <= req_we;
            to_ir_q   <= req_to_ir;
            cnt       <= req_we ? WR_INIT : RD_INIT;
            mem_wr    <= req_we;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!we_q) begin
              if (to_ir_q) ir  <= mem_rdata;
              else         mdr <= mem_rdata;
            end
            mem_wr <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Field decode is a pure slice of IR so the control unit sees it in the same cycle IR updates.
  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign rs     = ir[OPC_LSB-1 -: REG_W];
  assign rt     = ir[OPC_LSB-1-REG_W -: REG_W];
  assign rd     = ir[OPC_LSB-1-2*REG_W -: REG_W];
  assign funct  = ir[FUNCT_W-1:0];
  assign imm16  = ir[15:0];

endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// Scoreboarded bench: driver predicts IR/MDR from a word-array memory model, monitor checks on done/mem_wr.
module tb_fetch_mem_sequencer;
  import cpu_pkg::*;

  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 1;

  logic        clock, reset;
  logic        req, req_we, req_iord, req_to_ir;
  logic [31:0] pc_addr, alu_addr, wdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, busy, done, req_drop;
  logic [31:0] ir, mdr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  fetch_mem_sequencer #(.ADDR_W(32), .DATA_W(32), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we), .req_iord(req_iord),
    .req_to_ir(req_to_ir), .pc_addr(pc_addr), .alu_addr(alu_addr), .wdata(wdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .req_drop(req_drop), .ir(ir), .mdr(mdr),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory with one registered read stage; a preload port fills it during reset.
  logic [31:0] mem [256];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_dat;
  always @(posedge clock) begin
    if (ld_en)       mem[ld_idx] <= ld_dat;
    else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] wd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_ir, ref_mdr;
  bit          drop_exp;
  bit          untracked;
  int          n_cmp, n_bad;
  int          wr_cycles;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (mem_wr) begin
        if (exp_q.size() > 0) begin
          chk("wr_is_store", {31'd0, exp_q[0].we}, 32'd1);
          chk("wr_addr", mem_addr, exp_q[0].addr);
          chk("wr_data", mem_wdata, exp_q[0].wd);
          wr_cycles++;
        end else if (!untracked) begin
          chk("spurious_wr", {31'd0, mem_wr}, 32'd0);
        end
      end
      if (busy && exp_q.size() > 0) chk("addr_stable", mem_addr, exp_q[0].addr);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ir", ir, mon_e.ir);
          chk("mdr", mdr, mon_e.mdr);
          chk("opcode", {26'd0, opcode}, {26'd0, mon_e.ir[31:26]});
          chk("rs", {27'd0, rs}, {27'd0, mon_e.ir[25:21]});
          chk("rt", {27'd0, rt}, {27'd0, mon_e.ir[20:16]});
          chk("rd", {27'd0, rd}, {27'd0, mon_e.ir[15:11]});
          chk("funct", {26'd0, funct}, {26'd0, mon_e.ir[5:0]});
          chk("imm16", {16'd0, imm16}, {16'd0, mon_e.ir[15:0]});
          chk("wr_cycles", wr_cycles, mon_e.we ? WRITE_LAT : 0);
        end
        wr_cycles = 0;
      end
    end
  end

  // Issues one access at a negedge, updates the reference model and waits (bounded) for done.
  task automatic access(input logic we, input logic iord, input logic to_ir,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                        input bit poke, input bit bump);
    exp_t        e;
    logic [31:0] a;
    int          k;
    a = iord ? alu : pc;
    if (we) ref_mem[a[9:2]] = wd;
    else if (to_ir) ref_ir = ref_mem[a[9:2]];
    else ref_mdr = ref_mem[a[9:2]];
    e = '{we: we, addr: a, ir: ref_ir, mdr: ref_mdr, wd: wd};
    exp_q.push_back(e);
    if (poke) drop_exp = 1'b1;
    req = 1'b1; req_we = we; req_iord = iord; req_to_ir = to_ir;
    pc_addr = pc; alu_addr = alu; wdata = wd;
    @(negedge clock);
    req = poke;
    if (bump) pc_addr = pc + 32'd4;
    k = 1;
    while (!done && k < 16) begin
      @(negedge clock);
      req = 1'b0;
      k++;
    end
    chk("latency", k, (we ? WRITE_LAT : READ_LAT) + 1);
    chk("drop_at_done", {31'd0, req_drop}, {31'd0, drop_exp});
    req = poke;
    @(negedge clock);
    req = 1'b0;
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("drop_sticky", {31'd0, req_drop}, {31'd0, drop_exp});
  endtask

  initial begin
    logic [31:0] d;
    n_cmp = 0; n_bad = 0; wr_cycles = 0;
    drop_exp = 1'b0; untracked = 1'b0;
    ref_ir = '0; ref_mdr = '0;
    reset = 1'b1; req = 1'b0; req_we = 1'b0; req_iord = 1'b0; req_to_ir = 1'b0;
    pc_addr = '0; alu_addr = '0; wdata = '0;
    ld_en = 1'b0; ld_idx = '0; ld_dat = '0;

    @(negedge clock);
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      if (i == 16) d = 32'h8C22_0004;
      if (i == 64) d = 32'hDEAD_BEEF;
      ld_en = 1'b1; ld_idx = 8'(i); ld_dat = d; ref_mem[i] = d;
      @(negedge clock);
    end
    ld_en = 1'b0;
    @(negedge clock);

    chk("rst_ir", ir, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_flags", {28'd0, mem_wr, busy, done, req_drop}, 32'd0);
    chk("rst_fields", {opcode, funct, rs, rt, rd}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Instruction fetch into IR.
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t1_ir", ir, 32'h8C22_0004);
    chk("t1_opcode", {26'd0, opcode}, {26'd0, OP_LW});
    chk("t1_rs_rt", {22'd0, rs, rt}, {22'd0, 5'd1, 5'd2});
    chk("t1_imm16", {16'd0, imm16}, 32'd4);
    chk("t1_mdr", mdr, 32'd0);

    // Load into MDR.
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, 1'b0, 1'b0);
    chk("t2_mdr", mdr, 32'hDEAD_BEEF);
    chk("t2_ir", ir, 32'h8C22_0004);

    // Store.
    access(1'b1, 1'b1, 1'b0, 32'h40, 32'h104, 32'h1234_5678, 1'b0, 1'b0);
    chk("t3_mem", mem[65], 32'h1234_5678);
    chk("t3_ir_mdr", ir ^ mdr, 32'h8C22_0004 ^ 32'hDEAD_BEEF);

    // Requests during ACCESS and DONE are dropped.
    chk("t4_drop_before", {31'd0, req_drop}, 32'd0);
    access(1'b0, 1'b1, 1'b1, 32'h40, 32'h104, 32'h0, 1'b1, 1'b0);
    chk("t4_ir", ir, 32'h1234_5678);

    // PC moves mid-fetch; address must hold.
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("t5_ir", ir, 32'h8C22_0004);

    // Reset while mem_wr is high.
    untracked = 1'b1;
    req = 1'b1; req_we = 1'b1; req_iord = 1'b1; alu_addr = 32'h200; wdata = 32'hCAFE_F00D;
    @(negedge clock);
    req = 1'b0;
    chk("t6_wr_high", {31'd0, mem_wr}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t6_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_ir_mdr", ir | mdr, 32'd0);
    chk("t6_drop_cleared", {31'd0, req_drop}, 32'd0);
    ref_mem[128] = 32'hCAFE_F00D;
    ref_ir = '0; ref_mdr = '0; drop_exp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_done", {31'd0, done}, 32'd0);
      @(negedge clock);
    end
    untracked = 1'b0;
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 1'b0, 1'b0);
    chk("t6_recover_mdr", mdr, 32'hCAFE_F00D);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic        r_we;
      bit          r_poke;
      r_we   = ($urandom_range(0, 3) == 0);
      r_poke = !r_we && ($urandom_range(0, 4) == 0);
      access(r_we, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)) << 2, 32'($urandom_range(0, 255)) << 2,
             $urandom, r_poke, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
